// File: rtl/spiram_bus_bridge.sv
// Bridge between a FemtoRV-style CPU memory port and the SPI RAM controller.
// A masked 32-bit write is split into single-byte controller writes issued in
// ascending byte order; a read becomes one 32-bit controller read. All
// handshaking with the controller busy lines is absorbed here, so the CPU
// only sees mem_rbusy / mem_wbusy.
module spiram_bus_bridge #(
  parameter int ADDR_BITS     = 16,
  parameter int ISSUE_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          mem_address,
  input  logic [31:0]          mem_wdata,
  input  logic [3:0]           mem_wmask,
  input  logic                 mem_rstrb,
  output logic [31:0]          mem_rdata,
  output logic                 mem_rbusy,
  output logic                 mem_wbusy,
  output logic                 timeout_err,
  output logic                 ram_rd,
  output logic                 ram_wr,
  output logic [ADDR_BITS-1:0] ram_word_address,
  output logic [7:0]           ram_wdata,
  input  logic [31:0]          ram_rdata,
  input  logic                 ram_rbusy,
  input  logic                 ram_wbusy
);

  localparam int CNT_W = $clog2(ISSUE_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ISSUE_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    W_ISSUE = 3'd1,
    W_WAIT  = 3'd2,
    R_ISSUE = 3'd3,
    R_WAIT  = 3'd4
  } state_t;

  // Registered state
  state_t                 r_state;
  logic [ADDR_BITS-3:0]   r_addr;      // word part of the byte address
  logic [31:0]            r_wdata;
  logic [3:0]             r_mask;      // bytes still to be written
  logic                   r_pend_rd;   // read queued behind the current write
  logic [1:0]             r_byte_idx;  // byte currently owned by the controller
  logic [CNT_W-1:0]       r_cnt;       // issue timeout counter
  logic [31:0]            r_rdata;
  logic                   r_rbusy;
  logic                   r_wbusy;
  logic                   r_terr;

  // Next-state values
  state_t                 w_state_nxt;
  logic [ADDR_BITS-3:0]   w_addr_nxt;
  logic [31:0]            w_wdata_nxt;
  logic [3:0]             w_mask_nxt;
  logic                   w_pend_rd_nxt;
  logic [1:0]             w_byte_idx_nxt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic [31:0]            w_rdata_nxt;
  logic                   w_rbusy_nxt;
  logic                   w_wbusy_nxt;
  logic                   w_terr_nxt;

  logic [1:0]             w_idx;       // lowest remaining byte of the mask
  logic                   w_unused_addr;

  // Only the RAM byte address range (minus the byte lane) is forwarded.
  assign w_unused_addr = ^{mem_address[31:ADDR_BITS], mem_address[1:0]};

  function automatic logic [1:0] lowest_set(input logic [3:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else if (m[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  assign w_idx       = lowest_set(r_mask);
  assign mem_rdata   = r_rdata;
  assign mem_rbusy   = r_rbusy;
  assign mem_wbusy   = r_wbusy;
  assign timeout_err = r_terr;

  // State register and datapath registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!reset) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_mask     <= '0;
      r_pend_rd  <= 1'b0;
      r_byte_idx <= '0;
      r_cnt      <= '0;
      r_rdata    <= '0;
      r_rbusy    <= 1'b0;
      r_wbusy    <= 1'b0;
      r_terr     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_addr     <= w_addr_nxt;
      r_wdata    <= w_wdata_nxt;
      r_mask     <= w_mask_nxt;
      r_pend_rd  <= w_pend_rd_nxt;
      r_byte_idx <= w_byte_idx_nxt;
      r_cnt      <= w_cnt_nxt;
      r_rdata    <= w_rdata_nxt;
      r_rbusy    <= w_rbusy_nxt;
      r_wbusy    <= w_wbusy_nxt;
      r_terr     <= w_terr_nxt;
    end
  end

  // Next-state logic and controller-side outputs.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    w_state_nxt      = r_state;
    w_addr_nxt       = r_addr;
    w_wdata_nxt      = r_wdata;
    w_mask_nxt       = r_mask;
    w_pend_rd_nxt    = r_pend_rd;
    w_byte_idx_nxt   = r_byte_idx;
    w_cnt_nxt        = r_cnt;
    w_rdata_nxt      = r_rdata;
    w_rbusy_nxt      = r_rbusy;
    w_wbusy_nxt      = r_wbusy;
    w_terr_nxt       = r_terr;
    ram_rd           = 1'b0;
    ram_wr           = 1'b0;
    ram_word_address = '0;
    ram_wdata        = '0;

    unique case (r_state)
      IDLE: begin
        if (mem_wmask != 4'b0000) begin
          w_addr_nxt    = mem_address[ADDR_BITS-1:2];
          w_wdata_nxt   = mem_wdata;
          w_mask_nxt    = mem_wmask;
          w_wbusy_nxt   = 1'b1;
          w_pend_rd_nxt = mem_rstrb;
          w_rbusy_nxt   = mem_rstrb;
          w_cnt_nxt     = '0;
          w_state_nxt   = W_ISSUE;
        end else if (mem_rstrb) begin
          w_addr_nxt  = mem_address[ADDR_BITS-1:2];
          w_rbusy_nxt = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = R_ISSUE;
        end
      end

      W_ISSUE: begin
        ram_wr           = 1'b1;
        ram_word_address = {r_addr, w_idx};
        ram_wdata        = r_wdata[{w_idx, 3'b000} +: 8];
        w_byte_idx_nxt   = w_idx;
        // A byte whose strobe is never acknowledged is counted as written so
        // the rest of the word still goes out.
        if (ram_wbusy || (r_cnt == CNT_LAST)) begin
          w_mask_nxt[w_idx] = 1'b0;
          w_terr_nxt        = r_terr | ~ram_wbusy;
          w_state_nxt       = W_WAIT;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      W_WAIT: begin
        // Address and data stay on the byte the controller is writing.
        ram_word_address = {r_addr, r_byte_idx};
        ram_wdata        = r_wdata[{r_byte_idx, 3'b000} +: 8];
        if (!ram_wbusy) begin
          w_cnt_nxt = '0;
          if (r_mask != 4'b0000) begin
            w_state_nxt = W_ISSUE;
          end else begin
            w_wbusy_nxt = 1'b0;
            w_state_nxt = r_pend_rd ? R_ISSUE : IDLE;
          end
        end
      end

      R_ISSUE: begin
        ram_rd           = 1'b1;
        ram_word_address = {r_addr, 2'b00};
        if (ram_rbusy) begin
          w_state_nxt = R_WAIT;
        end else if (r_cnt == CNT_LAST) begin
          w_rdata_nxt   = 32'hFFFF_FFFF;
          w_rbusy_nxt   = 1'b0;
          w_pend_rd_nxt = 1'b0;
          w_terr_nxt    = 1'b1;
          w_state_nxt   = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      R_WAIT: begin
        ram_word_address = {r_addr, 2'b00};
        if (!ram_rbusy) begin
          w_rdata_nxt   = ram_rdata;
          w_rbusy_nxt   = 1'b0;
          w_pend_rd_nxt = 1'b0;
          w_state_nxt   = IDLE;
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spiram_bus_bridge.sv
// Directed bench for spiram_bus_bridge with a behavioural SPI RAM controller
// model that logs every accepted command.
module tb_spiram_bus_bridge;

  localparam int WR_DELAY = 2;
  localparam int WR_LEN   = 5;
  localparam int RD_DELAY = 2;
  localparam int RD_LEN   = 40;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] mem_address = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wmask = '0;
  logic        mem_rstrb = 1'b0;
  logic [31:0] mem_rdata;
  logic        mem_rbusy;
  logic        mem_wbusy;
  logic        timeout_err;
  logic        ram_rd;
  logic        ram_wr;
  logic [15:0] ram_word_address;
  logic [7:0]  ram_wdata;
  logic [31:0] ram_rdata = '0;
  logic        ram_rbusy;
  logic        ram_wbusy;

  int errors = 0;
  int checks = 0;

  spiram_bus_bridge #(.ADDR_BITS(16), .ISSUE_TIMEOUT(15)) dut (
    .clk              (clk),
    .reset            (reset),
    .mem_address      (mem_address),
    .mem_wdata        (mem_wdata),
    .mem_wmask        (mem_wmask),
    .mem_rstrb        (mem_rstrb),
    .mem_rdata        (mem_rdata),
    .mem_rbusy        (mem_rbusy),
    .mem_wbusy        (mem_wbusy),
    .timeout_err      (timeout_err),
    .ram_rd           (ram_rd),
    .ram_wr           (ram_wr),
    .ram_word_address (ram_word_address),
    .ram_wdata        (ram_wdata),
    .ram_rdata        (ram_rdata),
    .ram_rbusy        (ram_rbusy),
    .ram_wbusy        (ram_wbusy)
  );

  always #5 clk = ~clk;

  // ---------------- controller model ----------------
  typedef struct {
    logic        is_wr;
    logic [15:0] addr;
    logic [7:0]  data;
    int          wr_done_at;
  } cmd_t;

  typedef enum {M_IDLE, M_DELAY, M_BUSY} m_state_t;

  cmd_t        cmds[$];
  m_state_t    m_state = M_IDLE;
  int          m_cnt = 0;
  logic        m_is_wr = 1'b0;
  logic [15:0] m_addr = '0;
  logic [7:0]  m_data = '0;
  int          wr_done = 0;
  int          stab_err = 0;
  int          rd_hi = 0;
  int          both_hi = 0;
  bit          rd_never = 1'b0;

  always @(posedge clk) begin
    if (ram_rd) rd_hi <= rd_hi + 1;
    if (ram_rd && ram_wr) both_hi <= both_hi + 1;
    if (!reset) begin
      m_state   <= M_IDLE;
      m_cnt     <= 0;
      ram_rbusy <= 1'b0;
      ram_wbusy <= 1'b0;
    end else begin
      case (m_state)
        M_IDLE: begin
          if (ram_wr) begin
            cmds.push_back('{1'b1, ram_word_address, ram_wdata, wr_done});
            m_is_wr <= 1'b1;
            m_addr  <= ram_word_address;
            m_data  <= ram_wdata;
            m_cnt   <= WR_DELAY;
            m_state <= M_DELAY;
          end else if (ram_rd && !rd_never) begin
            cmds.push_back('{1'b0, ram_word_address, 8'h00, wr_done});
            m_is_wr <= 1'b0;
            m_addr  <= ram_word_address;
            m_cnt   <= RD_DELAY;
            m_state <= M_DELAY;
          end
        end
        M_DELAY: begin
          if (m_is_wr && (ram_word_address !== m_addr || ram_wdata !== m_data))
            stab_err <= stab_err + 1;
          if (m_cnt == 1) begin
            if (m_is_wr) ram_wbusy <= 1'b1;
            else         ram_rbusy <= 1'b1;
            m_cnt   <= m_is_wr ? WR_LEN : RD_LEN;
            m_state <= M_BUSY;
          end else begin
            m_cnt <= m_cnt - 1;
          end
        end
        default: begin
          if (m_is_wr && (ram_word_address !== m_addr || ram_wdata !== m_data))
            stab_err <= stab_err + 1;
          if (m_cnt == 1) begin
            ram_wbusy <= 1'b0;
            ram_rbusy <= 1'b0;
            if (m_is_wr) wr_done <= wr_done + 1;
            m_state <= M_IDLE;
          end else begin
            m_cnt <= m_cnt - 1;
          end
        end
      endcase
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic issue(input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] wm, input logic rs);
    @(negedge clk);
    mem_address = addr;
    mem_wdata   = wd;
    mem_wmask   = wm;
    mem_rstrb   = rs;
    @(negedge clk);
    mem_wmask   = 4'b0000;
    mem_rstrb   = 1'b0;
  endtask

  // sel 0: wait for mem_wbusy low, 1: mem_rbusy low, 2: both low
  task automatic wait_clear(input int sel, input int budget, input string name);
    int n = 0;
    while (((sel == 0) ? mem_wbusy : (sel == 1) ? mem_rbusy : (mem_wbusy | mem_rbusy))
           && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s: busy still high after %0d cycles", name, budget);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks += 8;
    if (mem_rdata !== 32'h0)    begin errors++; $display("FAIL rst_rdata: got %h want 0", mem_rdata); end
    if (mem_rbusy !== 1'b0)     begin errors++; $display("FAIL rst_rbusy: got %b want 0", mem_rbusy); end
    if (mem_wbusy !== 1'b0)     begin errors++; $display("FAIL rst_wbusy: got %b want 0", mem_wbusy); end
    if (timeout_err !== 1'b0)   begin errors++; $display("FAIL rst_terr: got %b want 0", timeout_err); end
    if (ram_rd !== 1'b0)        begin errors++; $display("FAIL rst_ram_rd: got %b want 0", ram_rd); end
    if (ram_wr !== 1'b0)        begin errors++; $display("FAIL rst_ram_wr: got %b want 0", ram_wr); end
    if (ram_word_address !== 16'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", ram_word_address); end
    if (ram_wdata !== 8'h0)     begin errors++; $display("FAIL rst_wdata: got %h want 0", ram_wdata); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    cmds.delete();
    ram_rdata = 32'hDEAD_BEEF;
    issue(32'h0000_1234, 32'h0, 4'b0000, 1'b1);
    checks++;
    if (mem_rbusy !== 1'b1) begin errors++; $display("FAIL rd_busy_set: got %b want 1", mem_rbusy); end
    wait_clear(1, 200, "rd_done");
    checks += 3;
    if (mem_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_data: got %h want deadbeef", mem_rdata); end
    if (cmds.size() !== 1) begin errors++; $display("FAIL rd_cmd_count: got %0d want 1", cmds.size()); end
    else if (cmds[0].is_wr !== 1'b0 || cmds[0].addr !== 16'h1234) begin
      errors++; $display("FAIL rd_cmd: got wr=%b addr=%h want wr=0 addr=1234", cmds[0].is_wr, cmds[0].addr);
    end
  endtask

  task automatic test_full_write();
    logic [15:0] exp_a [4] = '{16'h0100, 16'h0101, 16'h0102, 16'h0103};
    logic [7:0]  exp_d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    int w0 = wr_done;
    cmds.delete();
    issue(32'h0000_0100, 32'h4433_2211, 4'b1111, 1'b0);
    checks++;
    if (mem_wbusy !== 1'b1) begin errors++; $display("FAIL wr_busy_set: got %b want 1", mem_wbusy); end
    wait_clear(0, 300, "wr_done");
    checks += 2;
    if (wr_done - w0 !== 4) begin errors++; $display("FAIL wr_busy_early: wbusy falls seen %0d want 4", wr_done - w0); end
    if (cmds.size() !== 4) begin errors++; $display("FAIL wr_cmd_count: got %0d want 4", cmds.size()); end
    for (int i = 0; i < 4 && i < cmds.size(); i++) begin
      checks++;
      if (cmds[i].is_wr !== 1'b1 || cmds[i].addr !== exp_a[i] || cmds[i].data !== exp_d[i]) begin
        errors++;
        $display("FAIL wr_cmd%0d: got wr=%b addr=%h data=%h want wr=1 addr=%h data=%h",
                 i, cmds[i].is_wr, cmds[i].addr, cmds[i].data, exp_a[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_sparse_write();
    logic [15:0] exp_a [2] = '{16'h0201, 16'h0203};
    logic [7:0]  exp_d [2] = '{8'hCC, 8'hAA};
    cmds.delete();
    issue(32'h0000_0200, 32'hAABB_CCDD, 4'b1010, 1'b0);
    wait_clear(0, 300, "sparse_done");
    repeat (5) @(negedge clk);
    checks++;
    if (cmds.size() !== 2) begin errors++; $display("FAIL sparse_count: got %0d want 2", cmds.size()); end
    for (int i = 0; i < 2 && i < cmds.size(); i++) begin
      checks++;
      if (cmds[i].is_wr !== 1'b1 || cmds[i].addr !== exp_a[i] || cmds[i].data !== exp_d[i]) begin
        errors++;
        $display("FAIL sparse_cmd%0d: got wr=%b addr=%h data=%h want wr=1 addr=%h data=%h",
                 i, cmds[i].is_wr, cmds[i].addr, cmds[i].data, exp_a[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_simultaneous();
    cmds.delete();
    ram_rdata = 32'h1234_5678;
    issue(32'h0000_0300, 32'h0000_00A5, 4'b0001, 1'b1);
    checks += 2;
    if (mem_wbusy !== 1'b1) begin errors++; $display("FAIL sim_wbusy: got %b want 1", mem_wbusy); end
    if (mem_rbusy !== 1'b1) begin errors++; $display("FAIL sim_rbusy: got %b want 1", mem_rbusy); end
    wait_clear(0, 300, "sim_wr_done");
    checks++;
    if (mem_rbusy !== 1'b1) begin errors++; $display("FAIL sim_rbusy_held: got %b want 1", mem_rbusy); end
    wait_clear(1, 300, "sim_rd_done");
    checks += 2;
    if (mem_rdata !== 32'h1234_5678) begin errors++; $display("FAIL sim_rdata: got %h want 12345678", mem_rdata); end
    if (cmds.size() !== 2) begin errors++; $display("FAIL sim_count: got %0d want 2", cmds.size()); end
    else begin
      checks += 3;
      if (cmds[0].is_wr !== 1'b1 || cmds[0].addr !== 16'h0300 || cmds[0].data !== 8'hA5) begin
        errors++; $display("FAIL sim_wr_cmd: got wr=%b addr=%h data=%h want wr=1 addr=0300 data=a5",
                           cmds[0].is_wr, cmds[0].addr, cmds[0].data);
      end
      if (cmds[1].is_wr !== 1'b0 || cmds[1].addr !== 16'h0300) begin
        errors++; $display("FAIL sim_rd_cmd: got wr=%b addr=%h want wr=0 addr=0300", cmds[1].is_wr, cmds[1].addr);
      end
      if (cmds[1].wr_done_at !== cmds[0].wr_done_at + 1) begin
        errors++; $display("FAIL sim_order: read issued with %0d writes done want %0d",
                           cmds[1].wr_done_at - cmds[0].wr_done_at, 1);
      end
    end
  endtask

  task automatic test_read_timeout();
    int r0;
    rd_never = 1'b1;
    r0 = rd_hi;
    issue(32'h0000_0400, 32'h0, 4'b0000, 1'b1);
    wait_clear(1, 100, "to_done");
    checks += 4;
    if (rd_hi - r0 !== 15) begin errors++; $display("FAIL to_strobe_len: got %0d cycles want 15", rd_hi - r0); end
    if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_err: got %b want 1", timeout_err); end
    if (mem_rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL to_rdata: got %h want ffffffff", mem_rdata); end
    if (ram_rd !== 1'b0) begin errors++; $display("FAIL to_rd_drop: got %b want 0", ram_rd); end
    rd_never = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b want 1", timeout_err); end
  endtask

  task automatic test_reset_mid_write();
    int n = 0;
    cmds.delete();
    issue(32'h0000_0500, 32'h8765_4321, 4'b1111, 1'b0);
    while (!(cmds.size() == 2 && ram_wbusy && !ram_wr) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin errors++; $display("FAIL rmw_reach: second byte wait not reached in %0d cycles", n); end
    reset = 1'b0;
    @(negedge clk);
    checks += 6;
    if (mem_wbusy !== 1'b0)   begin errors++; $display("FAIL rmw_wbusy: got %b want 0", mem_wbusy); end
    if (mem_rbusy !== 1'b0)   begin errors++; $display("FAIL rmw_rbusy: got %b want 0", mem_rbusy); end
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL rmw_terr: got %b want 0", timeout_err); end
    if (mem_rdata !== 32'h0)  begin errors++; $display("FAIL rmw_rdata: got %h want 0", mem_rdata); end
    if (ram_wr !== 1'b0 || ram_rd !== 1'b0) begin
      errors++; $display("FAIL rmw_strobes: got rd=%b wr=%b want 0 0", ram_rd, ram_wr);
    end
    if (ram_word_address !== 16'h0 || ram_wdata !== 8'h0) begin
      errors++; $display("FAIL rmw_bus: got addr=%h data=%h want 0 0", ram_word_address, ram_wdata);
    end
    reset = 1'b1;
    @(negedge clk);
    cmds.delete();
    ram_rdata = 32'hCAFE_F00D;
    issue(32'h0000_0600, 32'h0, 4'b0000, 1'b1);
    wait_clear(2, 200, "rmw_read_done");
    checks += 2;
    if (mem_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL rmw_read_data: got %h want cafef00d", mem_rdata); end
    if (cmds.size() !== 1 || cmds[0].is_wr !== 1'b0 || cmds[0].addr !== 16'h0600) begin
      errors++; $display("FAIL rmw_read_cmd: got %0d cmds, want one read at 0600", cmds.size());
    end
  endtask

  task automatic test_protocol();
    checks += 2;
    if (both_hi !== 0)  begin errors++; $display("FAIL both_strobes: got %0d cycles want 0", both_hi); end
    if (stab_err !== 0) begin errors++; $display("FAIL wr_bus_stable: got %0d changes want 0", stab_err); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_full_write();
    test_sparse_write();
    test_simultaneous();
    test_read_timeout();
    test_reset_mid_write();
    test_protocol();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spiram_bus_bridge.md
Name: spiram_bus_bridge

Overview:
- Sits directly upstream of the SPI RAM controller and converts FemtoRV-style CPU memory transactions into that controller's command strobes.
- A 32-bit masked write becomes a sequence of single-byte SPI writes; a read becomes one 32-bit SPI read.
- Owns all handshaking with the controller's rbusy/wbusy, so the CPU sees a plain busy-stalled bus.

Parameters:
- ADDR_BITS, 16, width of RAM byte address forwarded to the controller.
- ISSUE_TIMEOUT, 15, cycles to wait for controller busy to rise after a strobe before abandoning that command.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset.
- mem_address  in  32  CPU byte address; only [ADDR_BITS-1:0] used.
- mem_wdata  in  32  CPU write data.
- mem_wmask  in  4  byte write enables; nonzero starts a write.
- mem_rstrb  in  1  read strobe, one cycle.
- mem_rdata  out  32  read data, registered.
- mem_rbusy  out  1  read in progress.
- mem_wbusy  out  1  write in progress.
- timeout_err  out  1  sticky; set when a command times out.
- ram_rd  out  1  read command strobe to controller.
- ram_wr  out  1  write command strobe to controller.
- ram_word_address  out  ADDR_BITS  address to controller.
- ram_wdata  out  8  byte to write.
- ram_rdata  in  32  controller read data, already byte-swizzled.
- ram_rbusy  in  1  controller read busy.
- ram_wbusy  in  1  controller write busy.

Behaviour:
- Reset values: all outputs 0, state IDLE, pending-read flag 0, byte index 0, timeout counter 0.
- States: IDLE, W_ISSUE, W_WAIT, R_ISSUE, R_WAIT.
- IDLE:
  - Accepts a request only here.
  - Nonzero wmask: latch address, wdata and wmask; set mem_wbusy the next cycle; go W_ISSUE.
  - rstrb in the same cycle as a nonzero wmask: set pending-read and set mem_rbusy as well. The write runs first, the read after.
  - rstrb alone: latch the address, set mem_rbusy, go R_ISSUE.
  - Requests arriving outside IDLE are ignored. The CPU must honour busy.
- W_ISSUE:
  - Select the lowest set bit i of the remaining mask.
  - Drive ram_wr=1, ram_word_address={addr[ADDR_BITS-1:2], i[1:0]}, ram_wdata=wdata[8i+7:8i].
  - Hold ram_wr until ram_wbusy=1 is sampled, then drop ram_wr, clear mask bit i, go W_WAIT.
  - ram_word_address and ram_wdata stay stable until ram_wbusy falls.
- W_WAIT:
  - On ram_wbusy=0: if mask bits remain, go W_ISSUE.
  - Otherwise clear mem_wbusy. If pending-read is set, go R_ISSUE; else go IDLE.
- R_ISSUE:
  - Drive ram_rd=1, ram_word_address={addr[ADDR_BITS-1:2], 2'b00}.
  - Hold until ram_rbusy=1 is sampled, then drop ram_rd and go R_WAIT.
- R_WAIT:
  - On ram_rbusy=0: mem_rdata <= ram_rdata, clear mem_rbusy and pending-read, go IDLE.
  - mem_rdata is valid in the first cycle mem_rbusy is low. It holds until the next read completes.
- Byte order: ascending byte index. Mask 4'b1010 issues byte 1, then byte 3.
- Timeout:
  - A counter runs in W_ISSUE and R_ISSUE and clears on each entry.
  - If it reaches ISSUE_TIMEOUT without busy rising: drop the strobe and set timeout_err.
  - Write: treat the byte as done and continue.
  - Read: load mem_rdata=32'hFFFF_FFFF, clear mem_rbusy, go IDLE.
- timeout_err clears only on reset.
- Strobes are never asserted in W_WAIT or R_WAIT, so the controller cannot re-trigger while it is in its START/WAIT_INST gap.
- Reset mid-operation: immediate return to the reset values next cycle. The strobes drop at once; the controller is reset by the same signal.
- Only ram_rd or ram_wr may be high in a cycle, never both.

Test Plan:
- Single read: addr 0x0000_1234, rstrb; the controller model raises rbusy 2 cycles later for 40 cycles and returns 0xDEADBEEF -> exactly one ram_rd with address 0x1234, mem_rdata=0xDEADBEEF, mem_rbusy falls the same cycle.
- Full-word write: addr 0x100, wdata 0x44332211, wmask 4'b1111 -> four ram_wr commands, (0x100,0x11), (0x101,0x22), (0x102,0x33), (0x103,0x44) in that order; mem_wbusy low only after the 4th wbusy falls.
- Sparse mask: wdata 0xAABBCCDD, wmask 4'b1010, addr 0x200 -> writes (0x201,0xCC) then (0x203,0xAA); no other strobes.
- Simultaneous: wmask 4'b0001 plus rstrb at addr 0x300 -> write (0x300) completes before ram_rd is asserted; both busies high until their own phase ends.
- Timeout: model never raises rbusy -> ram_rd drops after 15 cycles, timeout_err=1, mem_rdata=0xFFFFFFFF, mem_rbusy=0.
- Reset mid-write: assert reset during the 2nd byte's W_WAIT -> next cycle all outputs 0, state IDLE; a following read completes normally.
